key_led_bar: RTL and testbench

- Parametrised key-to-LED bar controller for N active-low push keys and N active-low LEDs.
- Each key is synchronised and debounced. Debounced key state drives a bar-graph LED display.
- Pressing key k lights LED0..LEDk.
- Two runtime modes:
  - momentary: the display follows the keys while they are held.
  - latched: the display holds the last selection, and pressing the same key again toggles it off.
- Sits directly between the board key pins and the board LED pins.

---
 rtl/key_led_bar.sv | 127 ++++++++++++
 tb/tb_key_led_bar.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_led_bar.sv
// Bar-graph LED controller: N active-low keys are synchronised, debounced and
// mapped to an active-low LED bar, either following the keys or latching a selection.
module key_led_bar #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    localparam int LVL_W          = $clog2(N_KEYS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key,
    input  logic              mode,
    output logic [N_KEYS-1:0] led,
    output logic [N_KEYS-1:0] key_db,
    output logic [N_KEYS-1:0] key_press,
    output logic [LVL_W-1:0]  level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_KEYS-1:0] sync1_q, sync1_d;
    logic [N_KEYS-1:0] sync2_q, sync2_d;
    logic [N_KEYS-1:0] key_db_q, key_db_d;
    logic [N_KEYS-1:0] key_press_q, key_press_d;
    logic [CNT_W-1:0]  cnt_q [N_KEYS];
    logic [CNT_W-1:0]  cnt_d [N_KEYS];
    logic              mode_q, mode_d;
    logic [LVL_W-1:0]  lat_q, lat_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [N_KEYS-1:0] led_q, led_d;

    logic [N_KEYS-1:0] pressed;
    logic [LVL_W-1:0]  mom_lvl;
    logic [LVL_W-1:0]  hit_lvl;

    always_comb begin
        sync1_d = key;
        sync2_d = sync1_q;
        mode_d  = mode;
    end

    // A counter only advances while the synced key disagrees with key_db;
    // any agreement wipes it, so a bounce never carries partial credit.
    always_comb begin
        key_db_d = key_db_q;
        for (int i = 0; i < N_KEYS; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != key_db_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    key_db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        key_press_d = key_db_q & ~key_db_d;
    end

    always_comb begin
        pressed = ~key_db_q;
        mom_lvl = '0;
        if (pressed != '0 && (pressed & (pressed - N_KEYS'(1))) == '0) begin
            for (int i = 0; i < N_KEYS; i++) begin
                if (pressed[i]) begin
                    mom_lvl = LVL_W'(i + 1);
                end
            end
        end
    end

    // Descending scan so the lowest pressed index is the one that sticks.
    always_comb begin
        hit_lvl = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (key_press_q[i]) begin
                hit_lvl = LVL_W'(i + 1);
            end
        end

        lat_d = lat_q;
        if (mode != mode_q) begin
            lat_d = '0;
        end else if (mode && (key_press_q != '0)) begin
            lat_d = (lat_q == hit_lvl) ? '0 : hit_lvl;
        end

        level_d = mode ? lat_d : mom_lvl;

        for (int i = 0; i < N_KEYS; i++) begin
            led_d[i] = !(i < int'(level_d));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            key_db_q    <= '1;
            key_press_q <= '0;
            mode_q      <= 1'b0;
            lat_q       <= '0;
            level_q     <= '0;
            led_q       <= '1;
            for (int i = 0; i < N_KEYS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            key_db_q    <= key_db_d;
            key_press_q <= key_press_d;
            mode_q      <= mode_d;
            lat_q       <= lat_d;
            level_q     <= level_d;
            led_q       <= led_d;
            for (int i = 0; i < N_KEYS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign led       = led_q;
    assign key_db    = key_db_q;
    assign key_press = key_press_q;
    assign level     = level_q;

endmodule

// File: tb/tb_key_led_bar.sv
// Scoreboard bench for key_led_bar: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them.
module tb_key_led_bar;

    logic       clk;
    logic       rst;
    logic [3:0] key;
    logic       mode;
    logic [3:0] led;
    logic [3:0] key_db;
    logic [3:0] key_press;
    logic [2:0] level;

    key_led_bar #(
        .N_KEYS          (4),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key       (key),
        .mode      (mode),
        .led       (led),
        .key_db    (key_db),
        .key_press (key_press),
        .level     (level)
    );

    typedef struct {
        int         cyc;
        logic [3:0] led;
        int         lvl;
        logic [3:0] db;
        logic [3:0] kp;
    } exp_t;

    exp_t  sb[$];
    string sb_name[$];
    int    cyc    = 0;
    int    n_cmp  = 0;
    int    n_bad  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_at(input int c, input string nm, input logic [3:0] l,
                          input int lv, input logic [3:0] d, input logic [3:0] p);
        exp_t e;
        e.cyc = c; e.led = l; e.lvl = lv; e.db = d; e.kp = p;
        sb.push_back(e);
        sb_name.push_back(nm);
    endtask

    always @(negedge clk) begin
        exp_t  e;
        string nm;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            nm = sb_name.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)", nm, e.cyc, cyc);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            nm = sb_name.pop_front();
            n_cmp++;
            if (led !== e.led || level !== 3'(e.lvl) || key_db !== e.db || key_press !== e.kp) begin
                n_bad++;
                $display("FAIL %s @cyc %0d: got led=%b level=%0d key_db=%b key_press=%b, want led=%b level=%0d key_db=%b key_press=%b",
                         nm, cyc, led, level, key_db, key_press, e.led, e.lvl, e.db, e.kp);
            end
        end
    end

    // Press a key pattern, release it, and check the display after the
    // debounced press and after the debounced release.
    task automatic press_rel(input string nm, input logic [3:0] keys, input logic [3:0] kp,
                             input logic [3:0] led0, input int lvl0,
                             input logic [3:0] led1, input int lvl1,
                             input logic [3:0] led2, input int lvl2);
        int e;
        e = cyc;
        key = keys;
        exp_at(e + 5, {nm, "_pre"},   led0, lvl0, 4'b1111, 4'b0000);
        exp_at(e + 6, {nm, "_db"},    led0, lvl0, keys,    kp);
        exp_at(e + 7, {nm, "_led"},   led1, lvl1, keys,    4'b0000);
        tick(8);
        e = cyc;
        key = 4'b1111;
        exp_at(e + 6, {nm, "_rel_db"},  led1, lvl1, 4'b1111, 4'b0000);
        exp_at(e + 7, {nm, "_rel_led"}, led2, lvl2, 4'b1111, 4'b0000);
        tick(10);
    endtask

    initial begin
        int e;
        rst  = 1'b1;
        key  = 4'b1111;
        mode = 1'b0;
        tick(2);
        n_cmp++;
        if (led !== 4'b1111) begin
            n_bad++;
            $display("FAIL rst_direct_led: got %b", led);
        end
        n_cmp++;
        if (key_db !== 4'b1111) begin
            n_bad++;
            $display("FAIL rst_direct_db: got %b", key_db);
        end
        n_cmp++;
        if (level !== 3'd0) begin
            n_bad++;
            $display("FAIL rst_direct_level: got %0d", level);
        end
        n_cmp++;
        if (key_press !== 4'b0000) begin
            n_bad++;
            $display("FAIL rst_direct_kp: got %b", key_press);
        end
        exp_at(cyc, "rst_init", 4'b1111, 0, 4'b1111, 4'b0000);

        // All keys held out of reset, then an asynchronous reset mid-cycle.
        rst = 1'b0;
        key = 4'b0000;
        e = cyc;
        exp_at(e + 5, "hold_pre", 4'b1111, 0, 4'b1111, 4'b0000);
        exp_at(e + 6, "hold_db",  4'b1111, 0, 4'b0000, 4'b1111);
        exp_at(e + 7, "hold_led", 4'b1111, 0, 4'b0000, 4'b0000);
        tick(8);
        #2;
        exp_at(cyc, "rst_async", 4'b1111, 0, 4'b1111, 4'b0000);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (led !== 4'b1111) begin
            n_bad++;
            $display("FAIL rst_async_led: got %b", led);
        end
        n_cmp++;
        if (key_db !== 4'b1111) begin
            n_bad++;
            $display("FAIL rst_async_db: got %b", key_db);
        end
        n_cmp++;
        if (level !== 3'd0) begin
            n_bad++;
            $display("FAIL rst_async_level: got %0d", level);
        end
        n_cmp++;
        if (key_press !== 4'b0000) begin
            n_bad++;
            $display("FAIL rst_async_kp: got %b", key_press);
        end
        tick(2);
        rst = 1'b0;
        e = cyc;
        exp_at(e + 5, "rst_rel_pre", 4'b1111, 0, 4'b1111, 4'b0000);
        exp_at(e + 6, "rst_rel_db",  4'b1111, 0, 4'b0000, 4'b1111);
        exp_at(e + 7, "rst_rel_one", 4'b1111, 0, 4'b0000, 4'b0000);
        tick(8);
        key = 4'b1111;
        e = cyc;
        exp_at(e + 6, "all_rel", 4'b1111, 0, 4'b1111, 4'b0000);
        tick(10);

        // Momentary latency and release.
        press_rel("mom_k1", 4'b1101, 4'b0010, 4'b1111, 0, 4'b1100, 2, 4'b1111, 0);

        // Bounce: alternate 0,1,0,1 then stay high.
        e = cyc;
        for (int i = 1; i <= 12; i++) exp_at(e + i, "bounce", 4'b1111, 0, 4'b1111, 4'b0000);
        key = 4'b1110; tick(1);
        key = 4'b1111; tick(1);
        key = 4'b1110; tick(1);
        key = 4'b1111; tick(10);

        // Low for three cycles only.
        e = cyc;
        for (int i = 1; i <= 12; i++) exp_at(e + i, "low3", 4'b1111, 0, 4'b1111, 4'b0000);
        key = 4'b1110; tick(3);
        key = 4'b1111; tick(10);

        // Low for four cycles: just enough.
        e = cyc;
        key = 4'b1110;
        exp_at(e + 5,  "low4_pre",     4'b1111, 0, 4'b1111, 4'b0000);
        exp_at(e + 6,  "low4_db",      4'b1111, 0, 4'b1110, 4'b0001);
        exp_at(e + 7,  "low4_led",     4'b1110, 1, 4'b1110, 4'b0000);
        exp_at(e + 10, "low4_rel_db",  4'b1110, 1, 4'b1111, 4'b0000);
        exp_at(e + 11, "low4_rel_led", 4'b1111, 0, 4'b1111, 4'b0000);
        tick(4);
        key = 4'b1111;
        tick(12);

        // Momentary multi-key, then key1 released leaving key3 alone.
        e = cyc;
        key = 4'b0101;
        exp_at(e + 6, "multi_db",  4'b1111, 0, 4'b0101, 4'b1010);
        exp_at(e + 7, "multi_led", 4'b1111, 0, 4'b0101, 4'b0000);
        tick(8);
        e = cyc;
        key = 4'b0111;
        exp_at(e + 6, "k3_db",  4'b1111, 0, 4'b0111, 4'b0000);
        exp_at(e + 7, "k3_led", 4'b0000, 4, 4'b0111, 4'b0000);
        tick(8);
        e = cyc;
        key = 4'b1111;
        exp_at(e + 7, "k3_rel", 4'b1111, 0, 4'b1111, 4'b0000);
        tick(10);

        // Latched mode sequence.
        mode = 1'b1;
        tick(3);
        press_rel("lat_k2",   4'b1011, 4'b0100, 4'b1111, 0, 4'b1000, 3, 4'b1000, 3);
        press_rel("lat_k2_off", 4'b1011, 4'b0100, 4'b1000, 3, 4'b1111, 0, 4'b1111, 0);
        press_rel("lat_k0",   4'b1110, 4'b0001, 4'b1111, 0, 4'b1110, 1, 4'b1110, 1);
        press_rel("lat_k3",   4'b0111, 4'b1000, 4'b1110, 1, 4'b0000, 4, 4'b0000, 4);
        press_rel("lat_k1k3", 4'b0101, 4'b1010, 4'b0000, 4, 4'b1100, 2, 4'b1100, 2);

        // Mode toggle clears the latched level.
        e = cyc;
        mode = 1'b0;
        exp_at(e + 1, "mode_to_mom", 4'b1111, 0, 4'b1111, 4'b0000);
        tick(3);
        mode = 1'b1;
        exp_at(e + 4, "mode_to_lat",  4'b1111, 0, 4'b1111, 4'b0000);
        exp_at(e + 6, "mode_lat_hold", 4'b1111, 0, 4'b1111, 4'b0000);
        tick(6);

        // Key held across a mode switch must not latch.
        e = cyc;
        key = 4'b1011;
        exp_at(e + 6, "held_db",  4'b1111, 0, 4'b1011, 4'b0100);
        exp_at(e + 7, "held_lat", 4'b1000, 3, 4'b1011, 4'b0000);
        tick(8);
        mode = 1'b0;
        exp_at(e + 9, "held_mom", 4'b1000, 3, 4'b1011, 4'b0000);
        tick(3);
        mode = 1'b1;
        exp_at(e + 12, "held_back",  4'b1111, 0, 4'b1011, 4'b0000);
        exp_at(e + 13, "held_nolat", 4'b1111, 0, 4'b1011, 4'b0000);
        tick(3);
        key = 4'b1111;
        exp_at(e + 20, "held_rel_db",  4'b1111, 0, 4'b1111, 4'b0000);
        exp_at(e + 21, "held_rel_led", 4'b1111, 0, 4'b1111, 4'b0000);
        tick(10);

        // Press pulse coinciding with a mode change is ignored.
        mode = 1'b0;
        tick(4);
        e = cyc;
        key = 4'b1101;
        exp_at(e + 6, "sw_press_db", 4'b1111, 0, 4'b1101, 4'b0010);
        tick(6);
        mode = 1'b1;
        exp_at(e + 7, "sw_press_ign", 4'b1111, 0, 4'b1101, 4'b0000);
        tick(2);
        key = 4'b1111;
        exp_at(e + 14, "sw_rel",      4'b1111, 0, 4'b1111, 4'b0000);
        exp_at(e + 15, "sw_rel_hold", 4'b1111, 0, 4'b1111, 4'b0000);
        tick(10);
        press_rel("lat_k1_fresh", 4'b1101, 4'b0010, 4'b1111, 0, 4'b1100, 2, 4'b1100, 2);

        for (int i = 0; i < 40 && sb.size() > 0; i++) @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            exp_t  x;
            string nm;
            x = sb.pop_front();
            nm = sb_name.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: expectation for cycle %0d still pending at end", nm, x.cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
